weight_fetch_biu: RTL and testbench

WEIGHT_FETCH_BIU -- requirements
Module: weight_fetch_biu

---
 rtl/weight_fetch_biu.sv | 190 +++++++++++++++++++
 tb/tb_weight_fetch_biu.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_fetch_biu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : weight_fetch_biu
// Purpose  : Weight-fetch bus interface unit. For one output channel it reads
//            the 3x3 weight block (9*in_grp words) and, if requested, the 1x1
//            block (in_grp words) from memory, keeping at most OUTS reads in
//            flight. It writes each returned word into the local weight buffer
//            at {seg, oc_idx, kpos, grp}.
// Ports    : clk, rst_n (async, active-low)
//            start/k1_en/in_grp/oc_idx/w3_base/w1_base : job descriptor
//            busy, done                                : job status
//            req_addr/req_vld/req_rdy                  : read request channel
//            rsp_data/rsp_vld/rsp_rdy                  : read response channel
//            wr_addr/wr_data/wr_en                     : buffer write port
// Revision : 1.0 - initial release
// ============================================================================
module weight_fetch_biu #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int GRP_W = 6,
  parameter int OUTS  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             k1_en,
  input  logic [GRP_W-1:0] in_grp,
  input  logic [7:0]       oc_idx,
  input  logic [AW-1:0]    w3_base,
  input  logic [AW-1:0]    w1_base,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    req_addr,
  output logic             req_vld,
  input  logic             req_rdy,
  input  logic [DW-1:0]    rsp_data,
  input  logic             rsp_vld,
  output logic             rsp_rdy,
  output logic [AW-1:0]    wr_addr,
  output logic [DW-1:0]    wr_data,
  output logic             wr_en
);

  // Request counters must hold 10*in_grp at most.
  localparam int CW    = GRP_W + 4;
  localparam int BYTES = DW / 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE3 = 2'd1,
    S_ISSUE1 = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_k1;
  logic [GRP_W-1:0] r_in_grp;
  logic [7:0]       r_oc;
  logic [AW-1:0]    r_w1_start;
  logic [AW-1:0]    r_req_addr;
  logic [CW-1:0]    r_iss_cnt;
  logic [CW-1:0]    r_rcv_cnt;
  logic [CW-1:0]    r_total;
  logic [3:0]       r_out_cnt;
  logic             r_seg;
  logic [3:0]       r_kpos;
  logic [GRP_W-1:0] r_grp;

  logic             w_start_acc;
  logic [AW-1:0]    w_off1;
  logic [AW-1:0]    w_off3;
  logic [CW-1:0]    w_in_ext;
  logic [CW-1:0]    w_new_total;
  logic [CW-1:0]    w_r_ext;
  logic [CW-1:0]    w_seg_target;
  logic             w_req_hs;
  logic             w_rsp_hs;
  logic             w_seg_last;

  assign w_start_acc = (r_state == S_IDLE) && start;

  // Start offsets are computed from the live inputs and captured with start.
  assign w_off1      = AW'(oc_idx) * AW'(in_grp) * AW'(BYTES);
  assign w_off3      = w_off1 * AW'(9);
  assign w_in_ext    = CW'(in_grp);
  assign w_new_total = (w_in_ext << 3) + w_in_ext + (k1_en ? w_in_ext : '0);

  assign w_r_ext      = CW'(r_in_grp);
  assign w_seg_target = (r_state == S_ISSUE1) ? w_r_ext : ((w_r_ext << 3) + w_r_ext);

  assign busy     = (r_state != S_IDLE);
  assign rsp_rdy  = busy;
  assign req_addr = r_req_addr;
  // The iss_cnt guard also keeps an empty job from ever raising req_vld.
  assign req_vld  = ((r_state == S_ISSUE3) || (r_state == S_ISSUE1)) &&
                    (r_iss_cnt < w_seg_target) && (r_out_cnt < 4'(OUTS));
  assign w_req_hs   = req_vld && req_rdy;
  assign w_seg_last = w_req_hs && (r_iss_cnt == (w_seg_target - CW'(1)));
  assign w_rsp_hs   = rsp_vld && rsp_rdy;
  assign wr_en      = w_rsp_hs;
  assign wr_data    = rsp_data;
  assign wr_addr    = AW'({r_seg, r_oc, r_kpos, r_grp});
  assign done       = (r_state == S_DRAIN) && (r_rcv_cnt == r_total);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_ISSUE3;
      S_ISSUE3: begin
        if (w_seg_target == '0)  w_next = S_DRAIN;
        else if (w_seg_last)     w_next = r_k1 ? S_ISSUE1 : S_DRAIN;
      end
      S_ISSUE1: if (w_seg_last) w_next = S_DRAIN;
      S_DRAIN:  if (done) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_k1       <= 1'b0;
      r_in_grp   <= '0;
      r_oc       <= '0;
      r_w1_start <= '0;
      r_req_addr <= '0;
      r_iss_cnt  <= '0;
      r_rcv_cnt  <= '0;
      r_total    <= '0;
      r_out_cnt  <= '0;
      r_seg      <= 1'b0;
      r_kpos     <= '0;
      r_grp      <= '0;
    end else begin
      r_state <= w_next;
      if (w_start_acc) begin
        r_k1       <= k1_en;
        r_in_grp   <= in_grp;
        r_oc       <= oc_idx;
        r_req_addr <= w3_base + w_off3;
        r_w1_start <= w1_base + w_off1;
        r_total    <= w_new_total;
        r_iss_cnt  <= '0;
        r_rcv_cnt  <= '0;
        r_out_cnt  <= '0;
        r_seg      <= 1'b0;
        r_kpos     <= '0;
        r_grp      <= '0;
      end else begin
        if (w_req_hs) begin
          if (w_seg_last) begin
            r_iss_cnt  <= '0;
            r_req_addr <= r_w1_start;
          end else begin
            r_iss_cnt  <= r_iss_cnt + CW'(1);
            r_req_addr <= r_req_addr + AW'(BYTES);
          end
        end

        if (w_req_hs && !w_rsp_hs)
          r_out_cnt <= r_out_cnt + 4'd1;
        else if (!w_req_hs && w_rsp_hs && (r_out_cnt != 4'd0))
          r_out_cnt <= r_out_cnt - 4'd1;

        // Responses arrive in request order, so the buffer address is a
        // running {seg, kpos, grp} count of the words written so far.
        if (w_rsp_hs) begin
          r_rcv_cnt <= r_rcv_cnt + CW'(1);
          if (r_grp == (r_in_grp - GRP_W'(1))) begin
            r_grp <= '0;
            if (!r_seg) begin
              if (r_kpos == 4'd8) begin
                r_kpos <= '0;
                r_seg  <= r_k1;
              end else begin
                r_kpos <= r_kpos + 4'd1;
              end
            end
          end else begin
            r_grp <= r_grp + GRP_W'(1);
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_weight_fetch_biu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_weight_fetch_biu
// Purpose  : Scoreboard bench for weight_fetch_biu. Stimulus pushes expected
//            request addresses and buffer writes; a monitor pops and compares
//            on every request handshake and write. A responder returns data
//            in order with one-cycle latency unless held back.
// Revision : 1.0 - initial release
// ============================================================================
module tb_weight_fetch_biu;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int GRP_W = 6;
  localparam int OUTS  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             k1_en = 1'b0;
  logic [GRP_W-1:0] in_grp = '0;
  logic [7:0]       oc_idx = '0;
  logic [AW-1:0]    w3_base = '0;
  logic [AW-1:0]    w1_base = '0;
  logic             busy, done;
  logic [AW-1:0]    req_addr;
  logic             req_vld;
  logic             req_rdy = 1'b0;
  logic [DW-1:0]    rsp_data = '0;
  logic             rsp_vld = 1'b0;
  logic             rsp_rdy;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             wr_en;

  weight_fetch_biu #(.AW(AW), .DW(DW), .GRP_W(GRP_W), .OUTS(OUTS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k1_en(k1_en), .in_grp(in_grp),
    .oc_idx(oc_idx), .w3_base(w3_base), .w1_base(w1_base), .busy(busy),
    .done(done), .req_addr(req_addr), .req_vld(req_vld), .req_rdy(req_rdy),
    .rsp_data(rsp_data), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_req = 0, n_wr = 0, n_done = 0, last_rsp_cyc = 0, done_base = 0;
  bit rsp_hold = 1'b0;
  logic [AW-1:0] exp_req[$];
  logic [AW-1:0] exp_wa[$];
  logic [DW-1:0] exp_wd[$];
  logic [AW-1:0] pend[$];
  logic [AW-1:0] obs_req[$];
  logic [AW-1:0] obs_wa[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic logic [DW-1:0] mem_f(logic [AW-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
  endfunction

  function automatic logic [AW-1:0] wa(int s, int oc, int kp, int g);
    return AW'(s * (1 << 18) + oc * (1 << 10) + kp * (1 << 6) + g);
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory responder: in-order, one cycle after the request handshake.
  initial forever begin
    @(posedge clk);
    #1;
    if (!rsp_hold && pend.size() > 0) begin
      rsp_vld  = 1'b1;
      rsp_data = mem_f(pend[0]);
    end else begin
      rsp_vld  = 1'b0;
      rsp_data = '0;
    end
  end

  // Monitor / scoreboard.
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  initial forever begin
    @(negedge clk);
    if (prev_stall) begin
      chk("req_vld_held", 64'(req_vld), 64'd1);
      chk("req_addr_held", 64'(req_addr), 64'(prev_addr));
    end
    prev_stall = rst_n && req_vld && !req_rdy;
    prev_addr  = req_addr;
    if (req_vld && req_rdy) begin
      n_req++;
      obs_req.push_back(req_addr);
      pend.push_back(req_addr);
      if (exp_req.size() == 0) begin
        checks++; errors++;
        $display("FAIL req_extra: actual addr 0x%0h required no request", req_addr);
      end else chk("req_addr", 64'(req_addr), 64'(exp_req.pop_front()));
    end
    if (rsp_vld && rsp_rdy) begin
      if (pend.size() > 0) void'(pend.pop_front());
      last_rsp_cyc = cyc;
    end
    if (wr_en) begin
      n_wr++;
      obs_wa.push_back(wr_addr);
      if (exp_wa.size() == 0) begin
        checks++; errors++;
        $display("FAIL wr_extra: actual wr_addr 0x%0h required no write", wr_addr);
      end else begin
        chk("wr_addr", 64'(wr_addr), 64'(exp_wa.pop_front()));
        chk("wr_data", 64'(wr_data), 64'(exp_wd.pop_front()));
      end
    end
    if (done) begin
      n_done++;
      chk("busy_with_done", 64'(busy), 64'd1);
    end
  end

  task automatic build_job(input bit k1, input int grp, input int oc,
                           input logic [AW-1:0] w3, input logic [AW-1:0] w1);
    logic [AW-1:0] a;
    logic [AW-1:0] reqs[$];
    int j;
    j = 0;
    a = w3 + AW'(oc * 9 * grp * 4);
    for (int i = 0; i < 9 * grp; i++) begin reqs.push_back(a); a = a + 4; end
    if (k1) begin
      a = w1 + AW'(oc * grp * 4);
      for (int i = 0; i < grp; i++) begin reqs.push_back(a); a = a + 4; end
    end
    for (int kp = 0; kp < 9; kp++)
      for (int g = 0; g < grp; g++) begin
        exp_wa.push_back(wa(0, oc, kp, g)); exp_wd.push_back(mem_f(reqs[j])); j++;
      end
    if (k1)
      for (int g = 0; g < grp; g++) begin
        exp_wa.push_back(wa(1, oc, 0, g)); exp_wd.push_back(mem_f(reqs[j])); j++;
      end
    foreach (reqs[i]) exp_req.push_back(reqs[i]);
  endtask

  // Drive a descriptor with a one-cycle start pulse, then scramble the inputs
  // so that anything not latched at start would corrupt the job.
  task automatic start_job(input bit k1, input int grp, input int oc,
                           input logic [AW-1:0] w3, input logic [AW-1:0] w1,
                           input bit exp_on, output int s);
    if (exp_on) build_job(k1, grp, oc, w3, w1);
    done_base = n_done;
    k1_en = k1; in_grp = GRP_W'(grp); oc_idx = 8'(oc); w3_base = w3; w1_base = w1;
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
    k1_en = !k1; in_grp = GRP_W'(grp + 3); oc_idx = oc_idx ^ 8'hFF;
    w3_base = ~w3; w1_base = ~w1;
  endtask

  task automatic wait_done(input int budget, output int d);
    d = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin d = cyc; break; end
    end
    if (d < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: actual no done required done within %0d cycles", budget);
    end
    tick();
  endtask

  task automatic end_job(output int d);
    wait_done(2000, d);
    tick(); tick();
    chk("exp_req_left", 64'(exp_req.size()), 64'd0);
    chk("exp_wr_left", 64'(exp_wa.size()), 64'd0);
    chk("done_pulses", 64'(n_done - done_base), 64'd1);
    chk("busy_after_job", 64'(busy), 64'd0);
  endtask

  task automatic chk_idle(string p);
    chk({p, "_busy"}, 64'(busy), 64'd0);
    chk({p, "_done"}, 64'(done), 64'd0);
    chk({p, "_req_vld"}, 64'(req_vld), 64'd0);
    chk({p, "_wr_en"}, 64'(wr_en), 64'd0);
    chk({p, "_rsp_rdy"}, 64'(rsp_rdy), 64'd0);
    chk({p, "_req_addr"}, 64'(req_addr), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual still running required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, d, b, bw, o, ow, bd, k;
    req_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk_idle("reset");
    rst_n = 1'b1;
    tick(); tick();

    // Full job: 36 3x3 reads from 0x1120, then 4 1x1 reads from 0x8020.
    b = n_req; bw = n_wr; o = obs_req.size(); ow = obs_wa.size();
    start_job(1'b1, 4, 2, 32'h1000, 32'h8000, 1'b1, s);
    end_job(d);
    chk("full_req_cnt", 64'(n_req - b), 64'd40);
    chk("full_wr_cnt", 64'(n_wr - bw), 64'd40);
    chk("full_first_addr", 64'(obs_req[o]), 64'h1120);
    chk("full_last3_addr", 64'(obs_req[o+35]), 64'h11AC);
    chk("full_first1_addr", 64'(obs_req[o+36]), 64'h8020);
    chk("full_last_wa", 64'(obs_wa[ow+39]), 64'h40803);
    chk("full_done_cyc", 64'(d), 64'(last_rsp_cyc + 1));

    // 3x3 only, one group: 9 reads from 0x200 + 5*9*4 = 0x2B4.
    b = n_req; o = obs_req.size(); ow = obs_wa.size();
    start_job(1'b0, 1, 5, 32'h200, 32'h7000, 1'b1, s);
    end_job(d);
    chk("k3_req_cnt", 64'(n_req - b), 64'd9);
    chk("k3_first_addr", 64'(obs_req[o]), 64'h2B4);
    chk("k3_last_wa", 64'(obs_wa[ow+8]), 64'h1600);
    chk("k3_done_cyc", 64'(d), 64'(last_rsp_cyc + 1));

    // Backpressure: responses withheld, only OUTS=2 reads go out.
    b = n_req;
    rsp_hold = 1'b1;
    start_job(1'b0, 1, 0, 32'h3000, 32'h0, 1'b1, s);
    for (int i = 0; i < 20 && (n_req - b) < 2; i++) tick();
    repeat (4) tick();
    chk("bp_req_cnt", 64'(n_req - b), 64'd2);
    @(negedge clk);
    chk("bp_vld_low", 64'(req_vld), 64'd0);
    @(posedge clk); #2;
    rsp_hold = 1'b0;
    req_rdy  = 1'b0;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_vld && rsp_rdy) begin k = 1; break; end
    end
    chk("bp_rsp_seen", 64'(k), 64'd1);
    chk("bp_vld_at_rsp", 64'(req_vld), 64'd0);
    @(negedge clk);
    chk("bp_vld_reassert", 64'(req_vld), 64'd1);
    chk("bp_addr", 64'(req_addr), 64'h3008);
    repeat (3) @(negedge clk);
    chk("bp_addr_stall", 64'(req_addr), 64'h3008);
    @(posedge clk); #2;
    req_rdy = 1'b1;
    end_job(d);
    chk("bp_req_total", 64'(n_req - b), 64'd9);

    // Start while busy is ignored.
    b = n_req; bw = n_wr; o = obs_req.size();
    start_job(1'b1, 2, 1, 32'h2000, 32'h3000, 1'b1, s);
    repeat (3) tick();
    chk("mid_busy", 64'(busy), 64'd1);
    in_grp = 6'd5; k1_en = 1'b0; oc_idx = 8'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    end_job(d);
    chk("mid_req_cnt", 64'(n_req - b), 64'd20);
    chk("mid_wr_cnt", 64'(n_wr - bw), 64'd20);
    chk("mid_first_addr", 64'(obs_req[o]), 64'h2048);
    repeat (3) tick();
    chk("mid_no_restart", 64'(busy), 64'd0);

    // Empty job: done two cycles after start, no traffic.
    b = n_req; bw = n_wr; bd = n_done;
    start_job(1'b1, 0, 3, 32'h5000, 32'h6000, 1'b1, s);
    chk("empty_busy", 64'(busy), 64'd1);
    chk("empty_no_vld", 64'(req_vld), 64'd0);
    wait_done(10, d);
    chk("empty_done_cyc", 64'(d - s), 64'd2);
    tick();
    chk("empty_idle", 64'(busy), 64'd0);
    chk("empty_done_cnt", 64'(n_done - bd), 64'd1);
    chk("empty_req_cnt", 64'(n_req - b), 64'd0);
    chk("empty_wr_cnt", 64'(n_wr - bw), 64'd0);

    // Reset in the middle of a job.
    b = n_req;
    start_job(1'b1, 4, 0, 32'h4000, 32'h9000, 1'b1, s);
    for (int i = 0; i < 200 && (n_req - b) < 10; i++) tick();
    chk("rst_reached_10", 64'((n_req - b) >= 10), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_idle("midrst");
    exp_req.delete(); exp_wa.delete(); exp_wd.delete();
    tick(); tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_wr_en", 64'(wr_en), 64'd0);
    pend.delete();
    tick(); tick();
    b = n_req; o = obs_req.size();
    start_job(1'b0, 2, 0, 32'h4000, 32'h9000, 1'b1, s);
    end_job(d);
    chk("clean_req_cnt", 64'(n_req - b), 64'd18);
    chk("clean_first_addr", 64'(obs_req[o]), 64'h4000);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
